// File: rtl/note_scroll_controller.sv
// Note field sequencer: once per scroll tick, erases the field, shifts it down one row,
// then redraws it. It also feeds row_data to the plotter and sends rows leaving the bottom to scoring.
//   state     | meaning
//   WAIT_TICK | counting unpaused cycles to the next scroll tick
//   ERASE     | plotter clearing the old field, waits for pass_done
//   SHIFT     | one cycle: field moves down one row, new row enters at top
//   DRAW      | plotter drawing the shifted field, waits for pass_done
module note_scroll_controller #(
  parameter int ROWS         = 8,
  parameter int TICK_CYCLES  = 3125000,
  parameter int PASS_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause_i,
  input  logic [4:0] new_row_i,
  input  logic       new_row_valid_i,
  output logic       new_row_ready_o,
  input  logic [2:0] row_sel_i,
  output logic [4:0] row_data_o,
  input  logic       pass_done_i,
  output logic       clear_note_o,
  output logic       plot_note_o,
  output logic       pass_reset_o,
  output logic [4:0] exit_row_o,
  output logic       exit_valid_o,
  output logic       timeout_err_o
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int PW = $clog2(PASS_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASS_TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_TICK, ERASE, SHIFT, DRAW} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [4:0]      field_q [ROWS];
  logic [4:0]      field_d [ROWS];
  logic [4:0]      exit_row_q, exit_row_d;
  logic            pass_reset_q, pass_reset_d;
  logic            timeout_q, timeout_d;
  logic            pass_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_TICK;
      tick_q       <= '0;
      pass_cnt_q   <= '0;
      exit_row_q   <= '0;
      pass_reset_q <= 1'b0;
      timeout_q    <= 1'b0;
      for (int r = 0; r < ROWS; r++) field_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      pass_cnt_q   <= pass_cnt_d;
      exit_row_q   <= exit_row_d;
      pass_reset_q <= pass_reset_d;
      timeout_q    <= timeout_d;
      field_q      <= field_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tick_d          = tick_q;
    pass_cnt_d      = '0;
    pass_reset_d    = 1'b0;
    timeout_d       = timeout_q;
    exit_row_d      = exit_row_q;
    field_d         = field_q;
    new_row_ready_o = 1'b0;
    // The pass counter is zero on the entry cycle, so a pass_done arriving then is ignored.
    pass_ok         = pass_done_i && (pass_cnt_q != '0);
    case (state_q)
      WAIT_TICK: begin
        if (!pause_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            state_d      = ERASE;
            pass_reset_d = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ERASE, DRAW: begin
        pass_cnt_d = pass_cnt_q + 1'b1;
        if (pass_ok) begin
          state_d = (state_q == ERASE) ? SHIFT : WAIT_TICK;
        end else if (pass_cnt_q == PASS_LAST) begin
          timeout_d = 1'b1;
          state_d   = WAIT_TICK;
        end
      end
      SHIFT: begin
        for (int r = 1; r < ROWS; r++) field_d[r] = field_q[r-1];
        field_d[0]      = new_row_valid_i ? new_row_i : 5'd0;
        new_row_ready_o = new_row_valid_i;
        exit_row_d      = field_q[ROWS-1];
        pass_reset_d    = 1'b1;
        state_d         = DRAW;
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  always_comb begin
    row_data_o = '0;
    if (int'(row_sel_i) < ROWS) row_data_o = field_q[row_sel_i];
  end

  assign clear_note_o  = (state_q == ERASE);
  assign plot_note_o   = (state_q == DRAW);
  assign exit_valid_o  = (state_q == SHIFT);
  // Exiting row is presented during SHIFT itself, then held until the next SHIFT.
  assign exit_row_o    = exit_valid_o ? field_q[ROWS-1] : exit_row_q;
  assign pass_reset_o  = pass_reset_q;
  assign timeout_err_o = timeout_q;

endmodule
